bdiv_44by22: RTL and testbench

BDIV_44BY22 -- requirements
Module: bdiv_44by22

---
 rtl/bdiv_pkg.sv | 20 ++
 rtl/bdiv_step.sv | 33 +++
 rtl/bdiv_44by22.sv | 151 +++++++++++++++
 tb/tb_bdiv_44by22.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bdiv_pkg.sv
// Shared defaults and FSM state encoding for the 44-by-22 restoring divider.
package bdiv_pkg;

  // Default operand widths: dividend is twice the divisor/quotient width.
  localparam int WN_DEF = 44;
  localparam int WD_DEF = 22;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bdiv_state_e;

  // Width of the step counter needed to count WD-1 down to 0.
  function automatic int cnt_width(input int wd);
    return (wd > 2) ? $clog2(wd) : 1;
  endfunction

endpackage

// File: rtl/bdiv_step.sv
// One radix-2 restoring division iteration: shift the next dividend bit into
// the partial remainder, trial-subtract the divisor and keep the difference
// only when it does not borrow.
module bdiv_step #(
  parameter int WD = 22
) (
  input  logic [WD-1:0] rem,
  input  logic          bit_in,
  input  logic [WD-1:0] d,
  output logic [WD-1:0] rem_out,
  output logic          q_bit
);

  // Shifted partial remainder needs one extra bit above WD.
  logic [WD:0] trial;
  // Low WD bits of the trial minus the divisor, with the borrow in the top bit.
  logic [WD:0] diff;
  logic        borrow;

  assign trial  = {rem, bit_in};
  assign diff   = {1'b0, trial[WD-1:0]} - {1'b0, d};
  assign borrow = diff[WD];

  // A set top bit means trial >= 2^WD > d, so the subtraction always applies;
  // the true difference is then below d and fits in the low WD bits.
  assign q_bit = trial[WD] | ~borrow;

  // Restoring mux, one bit per lane.
  for (genvar gi = 0; gi < WD; gi++) begin : g_rem_mux
    assign rem_out[gi] = q_bit ? diff[gi] : trial[gi];
  end

endmodule

// File: rtl/bdiv_44by22.sv
// Unsigned 44-by-22 restoring divider with valid/ready handshakes on both
// sides. One quotient bit is resolved per clock; divide-by-zero and quotient
// overflow are detected at accept time and reported without iterating.
module bdiv_44by22
  import bdiv_pkg::*;
#(
  parameter int WN = WN_DEF,
  parameter int WD = WD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WN-1:0] N,
  input  logic [WD-1:0] D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] Q,
  output logic [WD-1:0] R,
  output logic          div_zero,
  output logic          overflow
);

  localparam int CW = cnt_width(WD);
  localparam logic [CW-1:0] CNT_LAST = CW'(WD - 1);

  bdiv_state_e   state_reg, state_next;
  logic [WD-1:0] rem_reg,   rem_next;
  logic [WD-1:0] shf_reg,   shf_next;
  logic [WD-1:0] d_reg,     d_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [WD-1:0] q_reg,     q_next;
  logic [WD-1:0] r_reg,     r_next;
  logic          dz_reg,    dz_next;
  logic          ov_reg,    ov_next;

  logic [WD-1:0] step_rem;
  logic          step_q;
  logic [WD-1:0] n_hi;

  // Upper half of the dividend; the quotient fits only if this is below D.
  assign n_hi = N[WN-1:WD];

  // Shift register holds unconsumed dividend bits in its upper part and
  // collects quotient bits from the bottom, so its MSB is the next bit.
  bdiv_step #(
    .WD (WD)
  ) u_step (
    .rem     (rem_reg),
    .bit_in  (shf_reg[WD-1]),
    .d       (d_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // Next-state and datapath update logic.
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    shf_next   = shf_reg;
    d_next     = d_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dz_next    = dz_reg;
    ov_next    = ov_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          d_next = D;
          if (D == '0) begin
            dz_next    = 1'b1;
            ov_next    = 1'b0;
            q_next     = '1;
            r_next     = '0;
            state_next = DONE;
          end else if (n_hi >= D) begin
            dz_next    = 1'b0;
            ov_next    = 1'b1;
            q_next     = '1;
            r_next     = '0;
            state_next = DONE;
          end else begin
            dz_next    = 1'b0;
            ov_next    = 1'b0;
            rem_next   = n_hi;
            shf_next   = N[WD-1:0];
            cnt_next   = CNT_LAST;
            state_next = CALC;
          end
        end
      end

      CALC: begin
        rem_next = step_rem;
        shf_next = {shf_reg[WD-2:0], step_q};
        if (cnt_reg == '0) begin
          q_next     = {shf_reg[WD-2:0], step_q};
          r_next     = step_rem;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      shf_reg   <= '0;
      d_reg     <= '0;
      cnt_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dz_reg    <= 1'b0;
      ov_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      shf_reg   <= shf_next;
      d_reg     <= d_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dz_reg    <= dz_next;
      ov_reg    <= ov_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign Q         = q_reg;
  assign R         = r_reg;
  assign div_zero  = dz_reg;
  assign overflow  = ov_reg;

endmodule

// File: tb/tb_bdiv_44by22.sv
// Directed and random-product checks for bdiv_44by22 using an expected-result
// queue filled at accept time and drained when out_valid appears.
module tb_bdiv_44by22;

  localparam int WN = 44;
  localparam int WD = 22;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WN-1:0] n;
  logic [WD-1:0] d;
  logic          out_valid;
  logic          out_ready;
  logic [WD-1:0] q;
  logic [WD-1:0] r;
  logic          dz;
  logic          ov;

  typedef struct {
    logic [WN-1:0] n;
    logic [WD-1:0] d;
    logic [WD-1:0] q;
    logic [WD-1:0] r;
    logic          dz;
    logic          ov;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int   cmp_cnt = 0;
  int   mis_cnt = 0;

  bdiv_44by22 #(
    .WN (WN),
    .WD (WD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N         (n),
    .D         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (q),
    .R         (r),
    .div_zero  (dz),
    .overflow  (ov)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference behaviour: flags take priority, otherwise plain integer division.
  // Latency counts rising edges after the accept edge until out_valid.
  function automatic exp_t model(input logic [WN-1:0] nn, input logic [WD-1:0] dd);
    exp_t          e;
    logic [WN-1:0] dd_w;
    logic [WN-1:0] qq;
    logic [WN-1:0] rr;
    e.n = nn;
    e.d = dd;
    dd_w = {{(WN-WD){1'b0}}, dd};
    if (dd == '0) begin
      e.q = '1; e.r = '0; e.dz = 1'b1; e.ov = 1'b0; e.lat = 0;
    end else if (nn[WN-1:WD] >= dd) begin
      e.q = '1; e.r = '0; e.dz = 1'b0; e.ov = 1'b1; e.lat = 0;
    end else begin
      qq = nn / dd_w;
      rr = nn % dd_w;
      e.q = qq[WD-1:0]; e.r = rr[WD-1:0]; e.dz = 1'b0; e.ov = 1'b0; e.lat = WD;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    cmp_cnt++;
    assert (obs === expv) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Present one operand pair for a single edge; called at a falling edge.
  task automatic send(input logic [WN-1:0] nn, input logic [WD-1:0] dd);
    chk("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    n        = nn;
    d        = dd;
    sb.push_back(model(nn, dd));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Bounded wait for out_valid, counting rising edges after the accept edge.
  task automatic wait_out(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input exp_t e, input int lat);
    chk("latency", lat, e.lat);
    chk("out_valid", out_valid, 1);
    chk("in_ready_in_done", in_ready, 0);
    chk("Q", q, e.q);
    chk("R", r, e.r);
    chk("div_zero", dz, e.dz);
    chk("overflow", ov, e.ov);
    $display("op N=%011h D=%06h -> Q=%06h R=%06h dz=%0b ov=%0b lat=%0d",
             e.n, e.d, q, r, dz, ov, lat);
  endtask

  // Full transaction; with early set, out_ready is already high on DONE entry.
  task automatic run_op(input logic [WN-1:0] nn, input logic [WD-1:0] dd, input bit early);
    int   lat;
    exp_t e;
    out_ready = early;
    send(nn, dd);
    wait_out(lat);
    e = sb.pop_front();
    check_result(e, lat);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_handshake", out_valid, 0);
    chk("in_ready_after_handshake", in_ready, 1);
  endtask

  initial begin
    int            lat;
    exp_t          e;
    logic [WD-1:0] a;
    logic [WD-1:0] b;
    logic [WN-1:0] p;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n         = '0;
    d         = '0;

    // Reset state, observed while reset is held.
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_Q", q, 0);
    chk("rst_R", r, 0);
    chk("rst_div_zero", dz, 0);
    chk("rst_overflow", ov, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed values.
    run_op(44'd100, 22'd7, 1'b0);
    run_op(44'hFFFFF800001, 22'h3FFFFF, 1'b0);
    run_op(44'd5, 22'd0, 1'b0);
    run_op(44'h400000, 22'd1, 1'b0);
    run_op(44'h3FFFFF, 22'd1, 1'b0);
    run_op(44'd0, 22'd3, 1'b0);
    run_op(44'h3FFFFFFFFFF, 22'h3FFFFF, 1'b0);
    run_op(44'h3FFFFEFFFFF, 22'h3FFFFF, 1'b0);

    // Consumer already ready: exactly one cycle of out_valid.
    run_op(44'd987654321, 22'd12345, 1'b1);
    run_op(44'd9, 22'd0, 1'b1);

    // Backpressure in DONE with new operands pending on the input side.
    send(44'd12345, 22'd77);
    wait_out(lat);
    e = sb.pop_front();
    check_result(e, lat);
    in_valid = 1'b1;
    n        = 44'd5;
    d        = 22'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_Q_stable", q, e.q);
      chk("bp_R_stable", r, e.r);
      chk("bp_div_zero", dz, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_no_accept_in_ready", in_ready, 1);
    chk("bp_no_accept_out_valid", out_valid, 0);

    // Reset asserted partway through CALC aborts the operation.
    send(44'd123456789, 22'd999);
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("calc_out_valid", out_valid, 0);
    chk("calc_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_Q", q, 0);
    e = sb.pop_front();
    $display("op N=%011h D=%06h aborted by reset", e.n, e.d);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_no_result", out_valid, 0);
    run_op(44'd1000, 22'd10, 1'b0);

    // Products of two WD-bit values divide back exactly.
    for (int i = 0; i < 150; i++) begin
      a = WD'($urandom);
      b = WD'($urandom);
      if (b == '0) b = 22'd1;
      p = {{(WN-WD){1'b0}}, a} * {{(WN-WD){1'b0}}, b};
      run_op(p, b, (i % 4) == 0);
      chk("product_Q_equals_A", q_last_ok(a), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  // Quotient captured at the last result; held by the DUT after the handshake
  // because the output registers only change on the next completion.
  function automatic logic q_last_ok(input logic [WD-1:0] a_exp);
    return (q === a_exp) && (r === '0);
  endfunction

endmodule
